// File: rtl/gyro_tx_arb.sv
// Packet-granular 2:1 AXI-stream arbiter (s0 = DMA, s1 = command) with optional length cap.
// Optional stall watchdog enabled by defining GYRO_TX_ARB_WDOG_EN.
module gyro_tx_arb #(
    parameter int DW       = 32,
    parameter int LW       = 8,
    parameter int WDOG_CYC = 1024
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] s0_tdata,
    input  logic          s0_tvalid,
    input  logic          s0_tlast,
    output logic          s0_tready,
    input  logic [DW-1:0] s1_tdata,
    input  logic          s1_tvalid,
    input  logic          s1_tlast,
    output logic          s1_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    input  logic          cfg_prio,
    input  logic [LW-1:0] cfg_max_len,
    output logic [1:0]    grant,
    output logic          busy,
    output logic [15:0]   pkt_cnt0,
    output logic [15:0]   pkt_cnt1,
    output logic          err_trunc,
    output logic          err_wdog
);
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t        state, state_nx;
    logic          sel, sel_nx;
    logic          last_grant, last_grant_nx;
    logic          pick;
    logic [LW-1:0] beat_cnt, beat_cnt_nx;
    logic [LW-1:0] max_len_q, max_len_nx;
    logic          pkt_inc;
    logic          err_trunc_nx, err_wdog_nx;

    logic          own_valid, own_last, trunc_hit, hs, wdog_hit;
    logic [DW-1:0] own_data;

    assign own_valid = sel ? s1_tvalid : s0_tvalid;
    assign own_last  = sel ? s1_tlast  : s0_tlast;
    assign own_data  = sel ? s1_tdata  : s0_tdata;
    assign trunc_hit = (max_len_q != '0) && (beat_cnt == max_len_q - LW'(1));
    assign hs        = own_valid && m_tready;

`ifdef GYRO_TX_ARB_WDOG_EN
    localparam int SW = $clog2(WDOG_CYC + 1);
    logic [SW-1:0] stall_cnt;

    // Only an idle owner counts; downstream back-pressure keeps own_valid high.
    assign wdog_hit = (state != IDLE) && !own_valid && (stall_cnt == SW'(WDOG_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cnt <= '0;
        else if (state == IDLE || own_valid || wdog_hit)
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + SW'(1);
    end
`else
    logic wdog_unused;
    assign wdog_unused = (WDOG_CYC > 0);
    assign wdog_hit    = 1'b0;
`endif

    always_comb begin
        state_nx      = state;
        sel_nx        = sel;
        last_grant_nx = last_grant;
        beat_cnt_nx   = beat_cnt;
        max_len_nx    = max_len_q;
        pick          = 1'b0;
        pkt_inc       = 1'b0;
        err_trunc_nx  = 1'b0;
        err_wdog_nx   = 1'b0;
        m_tvalid      = 1'b0;
        m_tdata       = '0;
        m_tlast       = 1'b0;
        s0_tready     = 1'b0;
        s1_tready     = 1'b0;
        unique case (state)
            IDLE: begin
                max_len_nx  = cfg_max_len;
                beat_cnt_nx = '0;
                if (s0_tvalid || s1_tvalid) begin
                    if (cfg_prio)
                        pick = !s0_tvalid;
                    else if (s0_tvalid && s1_tvalid)
                        pick = !last_grant;
                    else
                        pick = s1_tvalid;
                    sel_nx        = pick;
                    last_grant_nx = pick;
                    state_nx      = GRANT;
                end
            end
            GRANT: begin
                m_tvalid  = own_valid;
                m_tdata   = own_data;
                m_tlast   = own_last || trunc_hit;
                s0_tready = !sel && m_tready;
                s1_tready = sel && m_tready;
                if (hs) begin
                    if (beat_cnt != '1)
                        beat_cnt_nx = beat_cnt + LW'(1);
                    if (own_last) begin
                        pkt_inc  = 1'b1;
                        state_nx = IDLE;
                    end else if (trunc_hit) begin
                        pkt_inc      = 1'b1;
                        err_trunc_nx = 1'b1;
                        state_nx     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Swallow the rest of the over-long packet without forwarding it.
                s0_tready = !sel;
                s1_tready = sel;
                if (own_valid && own_last)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (wdog_hit) begin
            state_nx      = IDLE;
            err_wdog_nx   = 1'b1;
            last_grant_nx = sel;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            max_len_q  <= '0;
            pkt_cnt0   <= '0;
            pkt_cnt1   <= '0;
            err_trunc  <= 1'b0;
            err_wdog   <= 1'b0;
            grant      <= 2'b00;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            last_grant <= last_grant_nx;
            beat_cnt   <= beat_cnt_nx;
            max_len_q  <= max_len_nx;
            err_trunc  <= err_trunc_nx;
            err_wdog   <= err_wdog_nx;
            busy       <= (state_nx != IDLE);
            grant      <= (state_nx == IDLE) ? 2'b00 : (sel_nx ? 2'b10 : 2'b01);
            if (pkt_inc) begin
                if (sel)
                    pkt_cnt1 <= pkt_cnt1 + 16'd1;
                else
                    pkt_cnt0 <= pkt_cnt0 + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_gyro_tx_arb.sv
// Randomized bench for gyro_tx_arb with a cycle-level reference model and directed scenarios.
module tb_gyro_tx_arb;
    localparam int DW = 32;
    localparam int LW = 8;
`ifdef GYRO_TX_ARB_WDOG_EN
    localparam int WDOG = 16;
`else
    localparam int WDOG = 1024;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic          s0_tvalid, s0_tlast, s0_tready;
    logic          s1_tvalid, s1_tlast, s1_tready;
    logic          m_tvalid, m_tlast, m_tready;
    logic          cfg_prio;
    logic [LW-1:0] cfg_max_len;
    logic [1:0]    grant;
    logic          busy, err_trunc, err_wdog;
    logic [15:0]   pkt_cnt0, pkt_cnt1;

    gyro_tx_arb #(.DW(DW), .LW(LW), .WDOG_CYC(WDOG)) dut (
        .clk(clk), .rstn(rstn),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .cfg_prio(cfg_prio), .cfg_max_len(cfg_max_len),
        .grant(grant), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
        .err_trunc(err_trunc), .err_wdog(err_wdog)
    );

    // source drivers
    logic          sv[2];
    logic          sl[2];
    logic [DW-1:0] sd[2];
    int            rem[2], idx[2], plen[2], pid[2], lenmode[2], vprob[2];
    bit            stall[2], hs[2];
    int            mr_mode;

    assign s0_tvalid = sv[0];
    assign s0_tlast  = sl[0];
    assign s0_tdata  = sd[0];
    assign s1_tvalid = sv[1];
    assign s1_tlast  = sl[1];
    assign s1_tdata  = sd[1];

    // reference model: owner (-1 = nobody), discard mode, last winner, beat count
    int          md_own, md_last, md_beats, md_max, md_stall, w, o;
    bit          md_drop, tr_pend, wd_pend, trunc;
    logic [15:0] md_cnt[2];
    logic        e_mv;
    logic        e_r[2];
    logic [1:0]  e_g;
    logic        e_b;

    int             tests, fails, trunc_seen, wdog_seen, n, c1, cnt;
    logic [DW:0]    mlog[$];
    logic [DW:0]    ex;
    int             lens[5] = '{0, 0, 1, 3, 6};

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(string name, int cyc);
        tests++;
        fails++;
        $display("FAIL %s: timed out after %0d cycles", name, cyc);
    endtask

    function automatic int pick_len(int s);
        return (lenmode[s] > 0) ? lenmode[s] : int'($urandom_range(1, 8));
    endfunction

    task automatic load(int s, int num, int len);
        rem[s] = num; idx[s] = 0; pid[s] = 0; lenmode[s] = len;
        plen[s] = pick_len(s); sv[s] = 1'b0; hs[s] = 1'b0; stall[s] = 1'b0;
    endtask

    // Apply the handshakes seen at the last negedge, then present the next beats.
    task automatic drive();
        for (int s = 0; s < 2; s++) begin
            if (hs[s]) begin
                sv[s] = 1'b0;
                idx[s]++;
                if (idx[s] == plen[s]) begin
                    idx[s] = 0; pid[s]++; rem[s]--; plen[s] = pick_len(s);
                end
                hs[s] = 1'b0;
            end
            if (!sv[s])
                sv[s] = (rem[s] > 0) && !stall[s] && (int'($urandom_range(99)) < vprob[s]);
            sd[s] = {s[0], 15'(pid[s]), 16'(idx[s])};
            sl[s] = (idx[s] == plen[s] - 1);
        end
        case (mr_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = !m_tready;
            default: m_tready = (int'($urandom_range(99)) < 70);
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_idle(int budget, string name);
        int k;
        k = 0;
        while (!(rem[0] == 0 && rem[1] == 0 && md_own < 0 && !sv[0] && !sv[1])) begin
            if (k >= budget) begin
                timeout(name, k);
                return;
            end
            step();
            k++;
        end
        step();
        step();
    endtask

    // compare + model advance, once per cycle away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk("rst_m_tvalid", m_tvalid, 0);
                chk("rst_m_tdata", m_tdata, 0);
                chk("rst_m_tlast", m_tlast, 0);
                chk("rst_s0_tready", s0_tready, 0);
                chk("rst_s1_tready", s1_tready, 0);
                chk("rst_grant", grant, 0);
                chk("rst_busy", busy, 0);
                chk("rst_pkt_cnt0", pkt_cnt0, 0);
                chk("rst_pkt_cnt1", pkt_cnt1, 0);
                chk("rst_err", {err_trunc, err_wdog}, 0);
                md_own = -1; md_drop = 0; md_last = 1; md_beats = 0; md_max = 0; md_stall = 0;
                md_cnt[0] = '0; md_cnt[1] = '0; tr_pend = 0; wd_pend = 0;
                hs[0] = 0; hs[1] = 0;
            end else begin
                e_mv = 0; e_r[0] = 0; e_r[1] = 0; e_g = 2'b00; e_b = 0;
                if (md_own >= 0) begin
                    e_g = (md_own == 1) ? 2'b10 : 2'b01;
                    e_b = 1;
                    if (md_drop) begin
                        e_r[md_own] = 1;
                    end else begin
                        e_mv = sv[md_own];
                        e_r[md_own] = m_tready;
                    end
                end
                chk("m_tvalid", m_tvalid, e_mv);
                chk("s0_tready", s0_tready, e_r[0]);
                chk("s1_tready", s1_tready, e_r[1]);
                chk("grant", grant, e_g);
                chk("busy", busy, e_b);
                chk("pkt_cnt0", pkt_cnt0, md_cnt[0]);
                chk("pkt_cnt1", pkt_cnt1, md_cnt[1]);
                chk("err_trunc", err_trunc, tr_pend);
                chk("err_wdog", err_wdog, wd_pend);
                if (e_mv) begin
                    chk("m_tdata", m_tdata, sd[md_own]);
                    chk("m_tlast", m_tlast, sl[md_own] || (md_max != 0 && md_beats == md_max - 1));
                end
                hs[0] = sv[0] && s0_tready;
                hs[1] = sv[1] && s1_tready;
                if (m_tvalid && m_tready) mlog.push_back({m_tlast, m_tdata});
                if (err_trunc) trunc_seen++;
                if (err_wdog) wdog_seen++;

                tr_pend = 0; wd_pend = 0;
                if (md_own < 0) begin
                    if (sv[0] || sv[1]) begin
                        if (cfg_prio) w = sv[0] ? 0 : 1;
                        else if (sv[0] && sv[1]) w = 1 - md_last;
                        else w = sv[0] ? 0 : 1;
                        md_own = w; md_last = w; md_beats = 0; md_max = int'(cfg_max_len);
                        md_drop = 0; md_stall = 0;
                    end
                end else begin
                    o = md_own;
                    if (!sv[o]) begin
                        md_stall++;
`ifdef GYRO_TX_ARB_WDOG_EN
                        if (md_stall == WDOG) begin
                            wd_pend = 1; md_last = o; md_own = -1;
                        end
`endif
                    end else begin
                        md_stall = 0;
                        if (md_drop) begin
                            if (sl[o]) md_own = -1;
                        end else if (m_tready) begin
                            trunc = (md_max != 0 && md_beats == md_max - 1);
                            if (md_beats < 255) md_beats++;
                            if (sl[o]) begin
                                md_cnt[o]++; md_own = -1;
                            end else if (trunc) begin
                                md_cnt[o]++; tr_pend = 1; md_drop = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        tests = 0; fails = 0; trunc_seen = 0; wdog_seen = 0;
        md_own = -1; md_last = 1; md_drop = 0; md_beats = 0; md_max = 0; md_stall = 0;
        md_cnt[0] = '0; md_cnt[1] = '0; tr_pend = 0; wd_pend = 0;
        cfg_prio = 0; cfg_max_len = '0; mr_mode = 0; m_tready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sv[s] = 0; vprob[s] = 100;
            load(s, 0, 1);
        end
        drive();
        #1 rstn = 1'b0;
        repeat (3) step();

        // T1: round-robin with both sources valid right out of reset
        load(0, 3, 4);
        load(1, 3, 4);
        mlog.delete();
        rstn = 1'b1;
        drive();
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (pkt_cnt1 != 16'(k + 1) && n < 200) begin step(); n++; end
            chk("t1_wait_cnt1", pkt_cnt1, k + 1);
            chk("t1_pair_cnt0", pkt_cnt0, k + 1);
        end
        wait_idle(200, "t1_idle");
        chk("t1_beats", mlog.size(), 24);
        for (int i = 0; i < mlog.size() && i < 24; i++) begin
            ex = {(i % 4 == 3), 1'((i / 4) % 2), 15'(i / 8), 16'(i % 4)};
            chk("t1_beat", mlog[i], ex);
        end

        // T2: fixed priority starves s1 while s0 keeps requesting
        cfg_prio = 1;
        load(0, 4, 2);
        load(1, 2, 2);
        mlog.delete();
        n = 0;
        while (rem[0] > 0 && n < 300) begin step(); n++; end
        chk("t2_cnt0", pkt_cnt0, 7);
        chk("t2_cnt1_hold", pkt_cnt1, 3);
        cnt = 0;
        foreach (mlog[i]) if (mlog[i][DW-1]) cnt++;
        chk("t2_s1_beats", cnt, 0);
        wait_idle(200, "t2_idle");
        chk("t2_cnt1_after", pkt_cnt1, 5);
        cfg_prio = 0;

        // T3: truncation at 3 beats, then max_len=1
        cfg_max_len = 8'd3;
        load(0, 1, 6);
        mlog.delete();
        trunc_seen = 0;
        wait_idle(200, "t3_idle");
        chk("t3_beats", mlog.size(), 3);
        for (int i = 0; i < mlog.size() && i < 3; i++) begin
            ex = {(i == 2), 32'(i)};
            chk("t3_beat", mlog[i], ex);
        end
        chk("t3_cnt0", pkt_cnt0, 8);
        chk("t3_trunc", trunc_seen, 1);

        cfg_max_len = 8'd1;
        load(1, 2, 3);
        mlog.delete();
        trunc_seen = 0;
        wait_idle(200, "t3b_idle");
        chk("t3b_beats", mlog.size(), 2);
        if (mlog.size() == 2) begin
            chk("t3b_beat0", mlog[0], {1'b1, 32'h8000_0000});
            chk("t3b_beat1", mlog[1], {1'b1, 32'h8001_0000});
        end
        chk("t3b_trunc", trunc_seen, 2);
        chk("t3b_cnt1", pkt_cnt1, 7);
        cfg_max_len = '0;

        // T4: downstream ready toggling during an s1 packet
        mr_mode = 1;
        load(1, 1, 4);
        mlog.delete();
        wait_idle(100, "t4_idle");
        chk("t4_beats", mlog.size(), 4);
        for (int i = 0; i < mlog.size() && i < 4; i++) begin
            ex = {(i == 3), 32'h8000_0000 + 32'(i)};
            chk("t4_beat", mlog[i], ex);
        end
        mr_mode = 0;

        // T5: reset in the middle of a packet
        load(0, 1, 5);
        n = 0;
        while (idx[0] != 2 && n < 50) begin step(); n++; end
        if (n >= 50) timeout("t5_reach", n);
        #1 rstn = 1'b0;
        #1;
        chk("t5_m_tvalid", m_tvalid, 0);
        chk("t5_s0_tready", s0_tready, 0);
        chk("t5_grant", grant, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cnt0", pkt_cnt0, 0);
        chk("t5_cnt1", pkt_cnt1, 0);
        load(0, 0, 1);
        step();
        step();
        rstn = 1'b1;
        load(1, 1, 2);
        mlog.delete();
        wait_idle(100, "t5_idle");
        chk("t5_after_cnt1", pkt_cnt1, 1);
        chk("t5_after_cnt0", pkt_cnt0, 0);
        chk("t5_after_beats", mlog.size(), 2);
        if (mlog.size() == 2) chk("t5_after_last", mlog[1], {1'b1, 32'h8000_0001});

        // T6: owner stalls mid-packet while the other source waits
        cfg_prio = 1;
        load(0, 1, 4);
        load(1, 1, 2);
        c1 = int'(pkt_cnt1);
        wdog_seen = 0;
        n = 0;
        while (!(idx[0] == 2 && md_own == 0) && n < 50) begin step(); n++; end
        if (n >= 50) timeout("t6_reach", n);
        stall[0] = 1;
        repeat (40) step();
`ifdef GYRO_TX_ARB_WDOG_EN
        chk("t6_wdog", wdog_seen, 1);
        chk("t6_cnt1", pkt_cnt1, c1 + 1);
`else
        chk("t6_grant_held", grant, 2'b01);
        chk("t6_cnt1", pkt_cnt1, c1);
        chk("t6_wdog", wdog_seen, 0);
`endif
        stall[0] = 0;
        wait_idle(200, "t6_idle");
        cfg_prio = 0;

        // T7: randomized traffic and configuration
        for (int r = 0; r < 8; r++) begin
            cfg_prio = 1'($urandom_range(1));
            cfg_max_len = LW'(lens[$urandom_range(4)]);
            vprob[0] = int'($urandom_range(50, 100));
            vprob[1] = int'($urandom_range(50, 100));
            mr_mode = 2;
            load(0, int'($urandom_range(1, 5)), 0);
            load(1, int'($urandom_range(1, 5)), 0);
            wait_idle(3000, "t7_idle");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gyro_tx_arb.md
# gyro_tx_arb

Packet-granular 2:1 AXI-stream arbiter that shares the single transmit stream into the bidirectional serial link between the DMA TX path (source 0) and a CPU/auxiliary command path (source 1). It sits between the TX FIFO output and the bidir block input. It guarantees that packets are never interleaved and optionally caps packet length. It also keeps per-source packet counters for CPU status readback.

## Interface
- DW, 32, data width of all streams
- LW, 8, width of cfg_max_len and the internal beat counter
- WDOG_CYC, 1024, stall cycles before watchdog abort (used only with GYRO_TX_ARB_WDOG_EN)
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- s0_tdata / s0_tvalid / s0_tlast  in  DW/1/1  source 0 stream (DMA)
- s0_tready  out  1  source 0 ready
- s1_tdata / s1_tvalid / s1_tlast  in  DW/1/1  source 1 stream (command)
- s1_tready  out  1  source 1 ready
- m_tdata / m_tvalid / m_tlast  out  DW/1/1  merged stream to the bidir block
- m_tready  in  1  downstream ready
- cfg_prio  in  1  0 = round-robin; 1 = fixed priority to s0
- cfg_max_len  in  LW  max beats per packet; 0 = unlimited
- grant  out  2  one-hot current owner (bit0 = s0, bit1 = s1)
- busy  out  1  state ≠ IDLE
- pkt_cnt0 / pkt_cnt1  out  16  completed packets per source; wrap at 0xFFFF→0
- err_trunc  out  1  one-cycle pulse on forced truncation
- err_wdog  out  1  one-cycle pulse on watchdog abort (tied 0 without macro)
- The block has one clock and an asynchronous, active-low reset: clk and rstn.

## Operation
- States: IDLE, GRANT (owner = sel), DRAIN (owner = sel).
- IDLE:
  - All treadys 0, m_tvalid 0.
  - If any s*_tvalid is high, select the owner: cfg_prio=1 → s0 wins if valid. cfg_prio=0 → when both are valid, the source opposite last_grant wins; otherwise the lone requester wins.
  - Next cycle → GRANT; sel and last_grant update; beat counter cleared.
- GRANT:
  - m_tdata/m_tvalid pass through combinationally from the owner; s<sel>_tready = m_tready; the other tready = 0.
  - m_tlast = s_tlast OR trunc_hit, where trunc_hit = (cfg_max_len≠0 and beat_cnt == cfg_max_len−1).
  - Each handshake increments beat_cnt; the counter saturates at all-ones.
  - Handshake with s_tlast=1 → increment pkt_cnt<sel>, → IDLE.
  - Handshake with trunc_hit=1 and s_tlast=0 → pulse err_trunc, increment pkt_cnt<sel>, → DRAIN.
- DRAIN:
  - s<sel>_tready = 1, m_tvalid = 0; owner beats are discarded.
  - Owner beat with tlast accepted → IDLE.
- cfg_prio and cfg_max_len are sampled only in IDLE (held in registers for the packet).
- Reset values: all outputs 0. Internally: state=IDLE, last_grant=s1 (so s0 wins the first tie), counters 0.
- Reset asserted mid-packet:
  - Immediate return to IDLE.
  - Downstream receives no tlast; upstream recovery is the system's responsibility.

## Timing
- Arbitration latency: 1 cycle from first tvalid in IDLE to m_tvalid.
- Throughput: 1 beat/cycle inside a packet; exactly 1 idle cycle between consecutive packets (IDLE state).
- No combinational path from m_tready to m_tvalid; the m_tready→s_tready path is combinational.
- grant and busy are registered and match the state.
- pkt_cnt updates on the cycle after the final handshake.
- err_* pulses are high for the one cycle following the triggering event.
- cfg_max_len=1: every packet is one beat with forced tlast.

## Configuration
- GYRO_TX_ARB_WDOG_EN defined:
  - In GRANT or DRAIN, a stall counter increments on each cycle with owner tvalid=0 and clears on any owner beat.
  - Reaching WDOG_CYC → err_wdog pulse, → IDLE without emitting tlast, and last_grant is set to the stalled source so the other source wins the next tie.
  - Downstream stall (m_tready=0) does not count.
- Not defined: no stall counter, err_wdog tied 0, and a stalled owner holds the grant indefinitely.

## Test plan
- Both sources valid at the first cycle after reset, each with 4-beat packets, cfg_prio=0 → the s0 packet followed by the s1 packet, alternating, with one gap cycle between packets; pkt_cnt0=pkt_cnt1 after each pair.
- cfg_prio=1, both continuously valid with 2-beat packets → only s0 is granted; pkt_cnt1 stays 0.
- cfg_max_len=3, s0 sends a 6-beat packet (tdata 0..5) → m carries 0,1,2 with tlast on 2, then an err_trunc pulse; beats 3..5 are dropped; pkt_cnt0=1.
- m_tready toggled 1-0-1-0 during a 4-beat s1 packet → all beats are delivered in order, s1_tready mirrors m_tready, and s0_tready stays 0 throughout.
- rstn pulsed low during beat 2 of a 5-beat packet → all outputs are 0 asynchronously and counters are 0; after release, the next packet is arbitrated normally from IDLE.
- With GYRO_TX_ARB_WDOG_EN and WDOG_CYC=16, s0 stalls mid-packet while s1 is valid → err_wdog pulses after 16 cycles and the s1 packet is granted next; without the macro, s0 retains the grant.
